// File: rtl/mips_arb_pkg.sv
// Shared types and constants for the MIPS memory arbiter.
package mips_arb_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_GNT_FETCH = 2'd1,
    ARB_GNT_DATA  = 2'd2,
    ARB_RESP      = 2'd3
  } arb_state_e;

  // Instruction returned to the fetch stage when memory never answers.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Width of the fetch starvation counter.
  localparam int STARVE_W = 8;

  // Saturating increment of the starvation counter.
  function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] cnt,
                                                     input logic [STARVE_W-1:0] lim);
    return (cnt < lim) ? cnt + 8'd1 : lim;
  endfunction

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Requester and memory handshake bundle around the arbiter.
// slave  = the arbiter's view; master = the surrounding core / memory model.
interface mips_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              FetchReq;
  logic [ADDR_W-1:0] FetchAddr;
  logic              FetchAck;
  logic [DATA_W-1:0] FetchInstr;
  logic              DataReq;
  logic              DataWrite;
  logic [ADDR_W-1:0] DataAddr;
  logic [DATA_W-1:0] DataWData;
  logic              DataAck;
  logic [DATA_W-1:0] DataRData;
  logic              MemReq;
  logic              MemWrite;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWData;
  logic              MemAck;
  logic [DATA_W-1:0] MemRData;
  logic              FetchStall;
  logic              DataStall;
  logic              BusError;

  modport slave (
    input  FetchReq, FetchAddr, DataReq, DataWrite, DataAddr, DataWData, MemAck, MemRData,
    output FetchAck, FetchInstr, DataAck, DataRData, MemReq, MemWrite, MemAddr, MemWData,
           FetchStall, DataStall, BusError
  );

  modport master (
    output FetchReq, FetchAddr, DataReq, DataWrite, DataAddr, DataWData, MemAck, MemRData,
    input  FetchAck, FetchInstr, DataAck, DataRData, MemReq, MemWrite, MemAddr, MemWData,
           FetchStall, DataStall, BusError
  );
endinterface

// File: rtl/mips_wait_timer.sv
// Clear/enable cycle counter with a terminal-count flag.
// tc is high during the cycle in which the count equals TERMINAL.
module mips_wait_timer #(
  parameter int WIDTH    = 4,
  parameter int TERMINAL = 14
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear wins, otherwise count up and stop at all-ones.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and the data
// stage: data first, fetch after STARVE_MAX back-to-back data grants, and a
// bus-error response when the memory stays silent for TIMEOUT cycles.
module mips_mem_arbiter
  import mips_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 15
) (
  input logic              ClockPulse,
  input logic              ResetN,
  mips_mem_arbiter_if.slave bus
);

  // The timer flags the TIMEOUT-th cycle spent in a grant state.
  localparam int WAIT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int WAIT_TERM = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  arb_state_e          state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                fetch_ack_q, fetch_ack_d;
  logic [DATA_W-1:0]   fetch_instr_q, fetch_instr_d;
  logic                data_ack_q, data_ack_d;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
  logic                bus_error_q, bus_error_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

  logic in_grant;
  logic wait_tc;
  logic timeout_hit;
  logic fetch_starved;

  assign in_grant      = (state_q == ARB_GNT_FETCH) || (state_q == ARB_GNT_DATA);
  assign timeout_hit   = (TIMEOUT != 0) && wait_tc;
  assign fetch_starved = bus.FetchReq && (starve_cnt_q == STARVE_LIM);

  mips_wait_timer #(
    .WIDTH    (WAIT_W),
    .TERMINAL (WAIT_TERM)
  ) u_wait_timer (
    .clk    (ClockPulse),
    .rst_n  (ResetN),
    .clear  (~in_grant),
    .enable (in_grant),
    .tc     (wait_tc)
  );

  // Arbitration, memory handshake and response formation.
  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_write_d   = mem_write_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    fetch_ack_d   = 1'b0;
    fetch_instr_d = fetch_instr_q;
    data_ack_d    = 1'b0;
    data_rdata_d  = data_rdata_q;
    bus_error_d   = 1'b0;
    starve_cnt_d  = starve_cnt_q;

    case (state_q)
      ARB_IDLE: begin
        if (!bus.FetchReq) begin
          starve_cnt_d = '0;
        end
        if (bus.DataReq && !fetch_starved) begin
          state_d     = ARB_GNT_DATA;
          mem_req_d   = 1'b1;
          mem_write_d = bus.DataWrite;
          mem_addr_d  = bus.DataAddr;
          mem_wdata_d = bus.DataWData;
          if (bus.FetchReq) begin
            starve_cnt_d = starve_inc(starve_cnt_q, STARVE_LIM);
          end
        end else if (bus.FetchReq) begin
          state_d      = ARB_GNT_FETCH;
          mem_req_d    = 1'b1;
          mem_write_d  = 1'b0;
          mem_addr_d   = bus.FetchAddr;
          starve_cnt_d = '0;
        end
      end

      ARB_GNT_FETCH, ARB_GNT_DATA: begin
        // A real answer in the timeout cycle takes precedence over the error.
        if (bus.MemAck || timeout_hit) begin
          state_d     = ARB_RESP;
          mem_req_d   = 1'b0;
          mem_write_d = 1'b0;
          bus_error_d = ~bus.MemAck;
          if (state_q == ARB_GNT_FETCH) begin
            fetch_ack_d   = 1'b1;
            fetch_instr_d = bus.MemAck ? bus.MemRData : DATA_W'(NOP_INSTR);
          end else begin
            data_ack_d = 1'b1;
            if (!mem_write_q) begin
              data_rdata_d = bus.MemAck ? bus.MemRData : '0;
            end
          end
        end
      end

      ARB_RESP: begin
        state_d = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // FSM state and all registered outputs.
  always_ff @(posedge ClockPulse or negedge ResetN) begin
    if (!ResetN) begin
      state_q       <= ARB_IDLE;
      mem_req_q     <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      fetch_ack_q   <= 1'b0;
      fetch_instr_q <= '0;
      data_ack_q    <= 1'b0;
      data_rdata_q  <= '0;
      bus_error_q   <= 1'b0;
      starve_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      fetch_ack_q   <= fetch_ack_d;
      fetch_instr_q <= fetch_instr_d;
      data_ack_q    <= data_ack_d;
      data_rdata_q  <= data_rdata_d;
      bus_error_q   <= bus_error_d;
      starve_cnt_q  <= starve_cnt_d;
    end
  end

  assign bus.MemReq     = mem_req_q;
  assign bus.MemWrite   = mem_write_q;
  assign bus.MemAddr    = mem_addr_q;
  assign bus.MemWData   = mem_wdata_q;
  assign bus.FetchAck   = fetch_ack_q;
  assign bus.FetchInstr = fetch_instr_q;
  assign bus.DataAck    = data_ack_q;
  assign bus.DataRData  = data_rdata_q;
  assign bus.BusError   = bus_error_q;
  assign bus.FetchStall = bus.FetchReq & ~fetch_ack_q;
  assign bus.DataStall  = bus.DataReq & ~data_ack_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: a table of single transactions plus
// hand-written sequences for contention, starvation and mid-transaction reset.
module tb_mips_mem_arbiter;
  import mips_arb_pkg::*;

  localparam int K_FETCH = 0;
  localparam int K_READ  = 1;
  localparam int K_WRITE = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_cyc;    // cycle memory acks (0 = never)
    logic [31:0] mem_rdata;
    int          exp_ack;    // expected Ack cycle
    logic [31:0] exp_data;   // expected FetchInstr / DataRData at the Ack
    logic        exp_berr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mips_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mips_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(15)
  ) dut (
    .ClockPulse (clk),
    .ResetN     (rst_n),
    .bus        (bus)
  );

  int errors = 0;
  int checks = 0;

  vec_t vecs [8];

  // free-run recordings
  logic [31:0] grant_q [$];
  int          data_ack_cyc, fetch_ack_cyc;
  logic [31:0] data_val, fetch_val;
  logic [7:0]  starve_snap [0:63];
  logic        fstall_snap [0:63];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  // One isolated transaction from IDLE; cycle 0 is the current cycle.
  task automatic run_txn(input int idx, input vec_t v);
    int          ack_cyc;
    logic [31:0] got_data, addr1, wdata1;
    logic        write1, got_berr, req_held, stray, stall0, req_low_at_ack;
    logic        own_ack, other_ack;
    ack_cyc = -1; got_data = '0; addr1 = '0; wdata1 = '0; write1 = 1'b0;
    got_berr = 1'b0; req_held = 1'b1; stray = 1'b0; stall0 = 1'b0; req_low_at_ack = 1'b0;
    bus.FetchReq  = (v.kind == K_FETCH);
    bus.FetchAddr = v.addr;
    bus.DataReq   = (v.kind != K_FETCH);
    bus.DataWrite = (v.kind == K_WRITE);
    bus.DataAddr  = v.addr;
    bus.DataWData = v.wdata;
    for (int cyc = 0; cyc < 40 && ack_cyc < 0; cyc++) begin
      bus.MemAck   = (v.ack_cyc != 0) && (cyc == v.ack_cyc);
      bus.MemRData = bus.MemAck ? v.mem_rdata : 32'h5A5A_5A5A;
      #1;
      if (cyc == 0) stall0 = (v.kind == K_FETCH) ? bus.FetchStall : bus.DataStall;
      if (cyc == 1) begin
        addr1 = bus.MemAddr; write1 = bus.MemWrite; wdata1 = bus.MemWData;
      end
      own_ack   = (v.kind == K_FETCH) ? bus.FetchAck : bus.DataAck;
      other_ack = (v.kind == K_FETCH) ? bus.DataAck : bus.FetchAck;
      if (other_ack) stray = 1'b1;
      if (own_ack) begin
        ack_cyc        = cyc;
        got_data       = (v.kind == K_FETCH) ? bus.FetchInstr : bus.DataRData;
        got_berr       = bus.BusError;
        req_low_at_ack = ~bus.MemReq;
        bus.FetchReq   = 1'b0;
        bus.DataReq    = 1'b0;
      end else begin
        if (bus.BusError) stray = 1'b1;
        if (cyc >= 1 && bus.MemReq !== 1'b1) req_held = 1'b0;
      end
      next_cycle();
    end
    bus.MemAck = 1'b0;
    check($sformatf("v%0d stall_c0", idx), {31'd0, stall0}, 32'd1);
    check($sformatf("v%0d mem_addr", idx), addr1, v.addr);
    check($sformatf("v%0d mem_write", idx), {31'd0, write1}, {31'd0, v.kind == K_WRITE});
    if (v.kind == K_WRITE) check($sformatf("v%0d mem_wdata", idx), wdata1, v.wdata);
    check($sformatf("v%0d mem_req_held", idx), {31'd0, req_held}, 32'd1);
    check($sformatf("v%0d ack_cycle", idx), ack_cyc, v.exp_ack);
    check($sformatf("v%0d ack_data", idx), got_data, v.exp_data);
    check($sformatf("v%0d bus_error", idx), {31'd0, got_berr}, {31'd0, v.exp_berr});
    check($sformatf("v%0d mem_req_low_at_ack", idx), {31'd0, req_low_at_ack}, 32'd1);
    check($sformatf("v%0d stray_ack_or_berr", idx), {31'd0, stray}, 32'd0);
    // now at cycle ack+1
    check($sformatf("v%0d idle_after", idx), 32'(dut.state_q), 32'(ARB_IDLE));
    check($sformatf("v%0d ack_one_cycle", idx), {31'd0, bus.FetchAck | bus.DataAck | bus.BusError}, 32'd0);
    $display("txn %0d kind=%0d addr=%h ack@%0d data=%h berr=%0b", idx, v.kind, v.addr, ack_cyc,
             got_data, got_berr);
  endtask

  // Free run with a memory that answers in the first grant cycle.
  task automatic free_run(input int ncyc, input logic hold_data);
    logic prev_req;
    prev_req = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      bus.MemAck   = bus.MemReq;
      bus.MemRData = bus.MemAddr ^ 32'hA5A5_0000;
      #1;
      if (bus.MemReq && !prev_req) grant_q.push_back(bus.MemAddr);
      prev_req       = bus.MemReq;
      starve_snap[c] = dut.starve_cnt_q;
      fstall_snap[c] = bus.FetchStall;
      if (bus.DataAck) begin
        if (data_ack_cyc < 0) begin
          data_ack_cyc = c;
          data_val     = bus.DataRData;
        end
        if (!hold_data) bus.DataReq = 1'b0;
      end
      if (bus.FetchAck) begin
        fetch_ack_cyc = c;
        fetch_val     = bus.FetchInstr;
        bus.FetchReq  = 1'b0;
      end
      next_cycle();
    end
    bus.MemAck = 1'b0;
  endtask

  task automatic clear_rec();
    grant_q.delete();
    data_ack_cyc  = -1;
    fetch_ack_cyc = -1;
    data_val      = '0;
    fetch_val     = '0;
  endtask

  initial begin
    logic no_ack;
    //             kind     addr          wdata         ack mem_rdata     exp_ack exp_data      berr
    vecs[0] = '{K_FETCH, 32'h0000_0040, 32'h0,         3, 32'h2008_0005,  4, 32'h2008_0005, 1'b0};
    vecs[1] = '{K_READ,  32'h0000_0100, 32'h0,         1, 32'h8C0A_0004,  2, 32'h8C0A_0004, 1'b0};
    vecs[2] = '{K_WRITE, 32'h0000_0200, 32'hDEAD_BEEF, 2, 32'h1234_5678,  3, 32'h8C0A_0004, 1'b0};
    vecs[3] = '{K_FETCH, 32'h0000_0044, 32'h0,         0, 32'h0,         16, 32'h0000_0000, 1'b1};
    vecs[4] = '{K_READ,  32'h0000_0104, 32'h0,        15, 32'hCAFE_F00D, 16, 32'hCAFE_F00D, 1'b0};
    vecs[5] = '{K_READ,  32'h0000_0108, 32'h0,         0, 32'h0,         16, 32'h0000_0000, 1'b1};
    vecs[6] = '{K_WRITE, 32'h0000_020C, 32'h0BAD_F00D, 0, 32'h0,         16, 32'h0000_0000, 1'b1};
    vecs[7] = '{K_FETCH, 32'h0000_0048, 32'h0,         1, 32'h0000_0020,  2, 32'h0000_0020, 1'b0};

    bus.FetchReq = 1'b0; bus.FetchAddr = '0; bus.DataReq = 1'b0; bus.DataWrite = 1'b0;
    bus.DataAddr = '0; bus.DataWData = '0; bus.MemAck = 1'b0; bus.MemRData = '0;
    rst_n = 1'b0;

    // reset state
    #12;
    check("rst mem_req", {31'd0, bus.MemReq}, 32'd0);
    check("rst fetch_ack", {31'd0, bus.FetchAck}, 32'd0);
    check("rst data_ack", {31'd0, bus.DataAck}, 32'd0);
    check("rst bus_error", {31'd0, bus.BusError}, 32'd0);
    check("rst mem_addr", bus.MemAddr, 32'd0);
    check("rst state", 32'(dut.state_q), 32'(ARB_IDLE));
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // table-driven single transactions
    for (int i = 0; i < 8; i++) begin
      run_txn(i, vecs[i]);
    end

    // simultaneous fetch + data read: data first, fetch after DataAck
    clear_rec();
    bus.FetchReq = 1'b1; bus.FetchAddr = 32'h0000_0080;
    bus.DataReq = 1'b1; bus.DataWrite = 1'b0; bus.DataAddr = 32'h0000_0100;
    free_run(8, 1'b0);
    check("sim grants", grant_q.size(), 32'd2);
    if (grant_q.size() >= 2) begin
      check("sim grant0", grant_q[0], 32'h0000_0100);
      check("sim grant1", grant_q[1], 32'h0000_0080);
    end
    check("sim data_ack_cyc", data_ack_cyc, 32'd2);
    check("sim data_rdata", data_val, 32'hA5A5_0100);
    check("sim fetch_ack_cyc", fetch_ack_cyc, 32'd5);
    check("sim fetch_instr", fetch_val, 32'hA5A5_0080);
    check("sim fstall_c4", {31'd0, fstall_snap[4]}, 32'd1);
    check("sim fstall_c5", {31'd0, fstall_snap[5]}, 32'd0);
    $display("txn sim grants=%0d data@%0d fetch@%0d", grant_q.size(), data_ack_cyc, fetch_ack_cyc);

    // starvation: DataReq held, fetch must win after 4 data grants
    clear_rec();
    bus.FetchReq = 1'b1; bus.FetchAddr = 32'h0000_0090;
    bus.DataReq = 1'b1; bus.DataWrite = 1'b0; bus.DataAddr = 32'h0000_0300;
    free_run(15, 1'b1);
    check("starve grants", grant_q.size(), 32'd5);
    for (int g = 0; g < 5 && g < grant_q.size(); g++) begin
      check($sformatf("starve grant%0d", g), grant_q[g], (g < 4) ? 32'h0000_0300 : 32'h0000_0090);
    end
    check("starve cnt_c12", {24'd0, starve_snap[12]}, 32'd4);
    check("starve cnt_c13", {24'd0, starve_snap[13]}, 32'd0);
    check("starve fetch_ack_cyc", fetch_ack_cyc, 32'd14);
    $display("txn starve grants=%0d fetch@%0d", grant_q.size(), fetch_ack_cyc);
    clear_rec();
    free_run(6, 1'b0);  // drain the trailing data request

    // write, then reset asserted while the grant is outstanding
    bus.DataReq = 1'b1; bus.DataWrite = 1'b1; bus.DataAddr = 32'h0000_0200;
    bus.DataWData = 32'hDEAD_BEEF;
    next_cycle();                      // cycle 1
    #1;
    check("wr mem_write", {31'd0, bus.MemWrite}, 32'd1);
    check("wr mem_wdata", bus.MemWData, 32'hDEAD_BEEF);
    check("wr data_stall", {31'd0, bus.DataStall}, 32'd1);
    next_cycle();                      // cycle 2
    check("wr mem_req_before_rst", {31'd0, bus.MemReq}, 32'd1);
    rst_n = 1'b0;
    bus.DataReq = 1'b0;
    #1;
    check("rst2 mem_req", {31'd0, bus.MemReq}, 32'd0);
    check("rst2 mem_write", {31'd0, bus.MemWrite}, 32'd0);
    check("rst2 mem_addr", bus.MemAddr, 32'd0);
    check("rst2 mem_wdata", bus.MemWData, 32'd0);
    check("rst2 fetch_instr", bus.FetchInstr, 32'd0);
    check("rst2 data_rdata", bus.DataRData, 32'd0);
    check("rst2 acks", {30'd0, bus.FetchAck, bus.DataAck}, 32'd0);
    check("rst2 bus_error", {31'd0, bus.BusError}, 32'd0);
    check("rst2 starve", {24'd0, dut.starve_cnt_q}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    no_ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.MemAck = 1'b1;               // late answer must be ignored
      #1;
      if (bus.DataAck || bus.FetchAck || bus.MemReq) no_ack = 1'b0;
      next_cycle();
    end
    bus.MemAck = 1'b0;
    check("rst2 no_ack_after", {31'd0, no_ack}, 32'd1);
    $display("txn reset_mid_write no_ack=%0b", no_ack);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_mem_arbiter.md
# mips_mem_arbiter

Shares one single-ported memory between the fetch stage (instruction reads) and the memory stage (data reads and writes) of the pipelined MIPS core. It grants one requester at a time, holds the memory handshake until the memory answers, and returns a one-cycle acknowledge with the result. It also drives the stall signals that freeze the IF/ID path or the pipeline while a request waits, prevents fetch starvation, and recovers from memory that never answers.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending (range 1..255)
- TIMEOUT, 15, maximum cycles in a grant state without MemAck; 0 disables the timeout

Ports:
- ClockPulse  in  1  clock; all state changes on its rising edge
- ResetN  in  1  asynchronous, active-low reset
- FetchReq  in  1  fetch request; held high until FetchAck
- FetchAddr  in  ADDR_W  fetch address; stable while FetchReq is high
- FetchAck  out  1  one-cycle pulse; FetchInstr is valid in that cycle
- FetchInstr  out  DATA_W  fetched instruction (registered)
- DataReq  in  1  data request; held high until DataAck
- DataWrite  in  1  1 = write, 0 = read; stable while DataReq is high
- DataAddr  in  ADDR_W  data address
- DataWData  in  DATA_W  write data
- DataAck  out  1  one-cycle pulse; DataRData is valid in that cycle for reads
- DataRData  out  DATA_W  read data (registered)
- MemReq  out  1  memory request; held until MemAck
- MemWrite  out  1  memory write enable
- MemAddr  out  ADDR_W  memory address
- MemWData  out  DATA_W  memory write data
- MemAck  in  1  memory completion; one cycle; MemRData is valid in that cycle
- MemRData  in  DATA_W  memory read data
- FetchStall  out  1  FetchReq & ~FetchAck (combinational)
- DataStall  out  1  DataReq & ~DataAck (combinational)
- BusError  out  1  one-cycle pulse when a transaction times out

## Operation
- States:
  - IDLE: no request being served.
  - GNT_FETCH: fetch request granted and waiting on memory.
  - GNT_DATA: data request granted and waiting on memory.
  - RESP: result presented to the requester.
- Arbitration in IDLE:
  - DataReq has priority over FetchReq.
  - Exception: when StarveCnt == STARVE_MAX and FetchReq is high, fetch wins.
  - With no request pending, the block stays in IDLE.
- StarveCnt (8-bit):
  - Increments on each data grant made while FetchReq is high.
  - Clears on a fetch grant, and in any IDLE cycle with FetchReq low.
  - Saturates at STARVE_MAX.
- In a grant state:
  - MemReq is 1.
  - MemAddr, MemWrite and MemWData are registered from the granted requester at grant time.
  - For fetch grants MemWrite = 0.
  - MemReq, MemAddr, MemWrite and MemWData stay constant until the state exits.
- On MemAck, go to RESP:
  - Fetch grant: FetchInstr <= MemRData.
  - Data read: DataRData <= MemRData.
  - Data write: DataRData is unchanged.
- RESP:
  - The Ack for the served requester is 1 for this cycle only.
  - Both Req inputs are ignored in this cycle.
  - The next state is always IDLE.
  - A Req still high in IDLE is treated as a new request.
- WaitCnt counts cycles in a grant state. When TIMEOUT != 0 and WaitCnt reaches TIMEOUT with MemAck low:
  - MemReq drops.
  - Go to RESP with the Ack asserted and BusError = 1 in that same cycle.
  - A fetch returns FetchInstr = 0 (NOP).
  - A data read returns DataRData = 0.
- MemAck in the same cycle as the timeout: MemAck wins and BusError stays 0.
- MemAck while in IDLE or RESP is ignored.

## Timing
- Reset values:
  - State = IDLE.
  - MemReq, MemWrite, FetchAck, DataAck and BusError = 0.
  - MemAddr, MemWData, FetchInstr and DataRData = 0.
  - StarveCnt and WaitCnt = 0.
- Reset asserted mid-transaction aborts it immediately: MemReq falls asynchronously and no Ack is issued.
- Latency, with the request seen in IDLE at cycle 0:
  - MemReq rises at cycle 1.
  - MemAck at cycle k (k ≥ 1) gives the Ack at cycle k+1.
  - Best case: Ack at cycle 2, IDLE again at cycle 3.
  - Peak throughput is one transaction per 3 cycles.
- Timeout case: BusError and Ack occur at cycle TIMEOUT+1.
- FetchStall and DataStall are combinational; every other output is registered.

## Structure
- Shared package/include mips_arb_pkg:
  - State encodings ARB_IDLE, ARB_GNT_FETCH, ARB_GNT_DATA, ARB_RESP.
  - The NOP constant, 32'h0000_0000.
- One sub-module: mips_wait_timer, a clear/enable counter with a terminal-count output. It holds WaitCnt; StarveCnt stays in the top-level block.
- The block is instantiated between Mips_Fetch/the memory stage and the memory model in the core top level.

## Test plan
- Lone fetch: FetchReq with FetchAddr = 0x40 at cycle 0; memory acks at cycle 3 with 0x2008_0005.
  - Expect MemReq high for cycles 1–3 with MemAddr = 0x40 and MemWrite = 0.
  - Expect FetchAck and FetchInstr = 0x2008_0005 at cycle 4.
  - Expect FetchStall = 1 for cycles 0–3.
- Simultaneous requests: FetchReq and DataReq (read of 0x100) together.
  - Data is served first; fetch is granted in the IDLE cycle after the DataAck.
  - DataRData holds the memory word; FetchAck comes later.
- Starvation: DataReq held continuously and FetchReq high, STARVE_MAX = 4.
  - Expect exactly 4 data grants, then a fetch grant, then StarveCnt = 0.
- Timeout: fetch granted with MemAck never asserted, TIMEOUT = 15.
  - Expect BusError, FetchAck and FetchInstr = 0 at cycle 16.
  - Expect MemReq low at cycle 16 and the state back in IDLE at cycle 17.
  - Second case: MemAck exactly at the timeout cycle gives no BusError and the real data.
- Write and reset:
  - Data write of 0xDEAD_BEEF to 0x200: expect MemWrite = 1 and MemWData = 0xDEAD_BEEF, with DataRData unchanged at the Ack.
  - Repeat the write and pulse ResetN low at cycle 2: expect MemReq = 0 immediately, no Ack, and all outputs back at their reset values.
